light_hash_param: RTL and testbench



---
 rtl/light_hash_pkg.sv | 23 ++
 rtl/lh_aes_sbox.sv | 29 ++
 rtl/light_hash_param.sv | 145 ++++++++++++++
 tb/tb_light_hash_param.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/light_hash_pkg.sv
// Shared definitions for the parametrised light hash core: command codes,
// FSM states and the per-lane byte rotation used by the round function.
package light_hash_pkg;

  localparam logic [1:0] CMD_HEAD = 2'b00;
  localparam logic [1:0] CMD_TAIL = 2'b01;
  localparam logic [1:0] CMD_MSG  = 2'b10;
  localparam logic [1:0] CMD_RSVD = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ABSORB = 2'd1,
    FINAL  = 2'd2,
    DONE   = 2'd3
  } lh_state_t;

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int unsigned s);
    logic [15:0] d;
    d = {x, x} << (s % 8);
    return d[15:8];
  endfunction

endpackage

// File: rtl/lh_aes_sbox.sv
// Combinational AES forward S-box; byte 0 of the table sits in the top bits.
module lh_aes_sbox (
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  localparam logic [2047:0] TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // (255 - in_byte) * 8 + 7 is the MSB of the selected entry
  assign out_byte = TBL[{~in_byte, 3'b111} -: 8];

endmodule

// File: rtl/light_hash_param.sv
// Parametrised light hash core: HEAD/MSG/TAIL framed byte absorption with
// S-box rounds, a length trailer on TAIL and a registered valid/ready handshake.
module light_hash_param
  import light_hash_pkg::*;
#(
  parameter int unsigned           DIGEST_W  = 64,
  parameter int unsigned           ROUNDS    = 32,
  parameter int unsigned           LEN_BYTES = 1,
  parameter logic [DIGEST_W-1:0]   IV        = 64'h0123456789abcdef
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          cmd,
  input  logic [7:0]          msg_byte,
  input  logic                msg_valid,
  output logic                msg_ready,
  output logic [DIGEST_W-1:0] digest,
  output logic                digest_ready,
  output logic                busy
);

  localparam int unsigned N     = DIGEST_W / 8;
  localparam int unsigned LEN_W = (LEN_BYTES == 0) ? 1 : 8 * LEN_BYTES;

  lh_state_t           state, state_n;
  logic [DIGEST_W-1:0] h, h_round, digest_q;
  logic [7:0]          b, b_cur, len_byte, rnd;
  logic [1:0]          lb;
  logic [LEN_W-1:0]    len;
  logic                digest_ready_q;
  logic                accept, last_rnd, last_lb;
  logic                do_head, do_msg, do_tail, do_round;

  assign msg_ready    = (state == IDLE) || (state == DONE);
  assign busy         = (state == ABSORB) || (state == FINAL);
  assign digest       = digest_q;
  assign digest_ready = digest_ready_q;

  assign accept   = msg_valid & msg_ready;
  assign last_rnd = (rnd == 8'(ROUNDS - 1));
  assign last_lb  = (lb == 2'(LEN_BYTES - 1));
  assign len_byte = 8'(len >> {lb, 3'b000});
  assign b_cur    = (state == FINAL) ? len_byte : b;

  // H'[i] = SBOX(H[i+1 mod N] ^ B) ^ rotl8(H[i], i mod 8), all lanes in parallel
  for (genvar gi = 0; gi < N; gi++) begin : g_lane
    logic [7:0] sb;
    lh_aes_sbox u_sbox (
      .in_byte  (h[((gi + 1) % N) * 8 +: 8] ^ b_cur),
      .out_byte (sb)
    );
    assign h_round[gi*8 +: 8] = sb ^ rotl8(h[gi*8 +: 8], gi % 8);
  end

  always_comb begin
    state_n  = state;
    do_head  = 1'b0;
    do_msg   = 1'b0;
    do_tail  = 1'b0;
    do_round = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          unique case (cmd)
            CMD_HEAD: do_head = 1'b1;
            CMD_MSG: begin
              do_msg  = 1'b1;
              state_n = ABSORB;
            end
            CMD_TAIL: begin
              do_tail = 1'b1;
              state_n = (LEN_BYTES == 0) ? DONE : FINAL;
            end
            default: ;
          endcase
        end
      end
      ABSORB: begin
        do_round = 1'b1;
        if (last_rnd) state_n = IDLE;
      end
      FINAL: begin
        do_round = 1'b1;
        if (last_rnd && last_lb) state_n = DONE;
      end
      DONE: begin
        if (accept && cmd == CMD_HEAD) begin
          do_head = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h              <= IV;
      b              <= '0;
      rnd            <= '0;
      lb             <= '0;
      len            <= '0;
      digest_q       <= '0;
      digest_ready_q <= 1'b0;
    end else begin
      if (do_head) begin
        h              <= IV;
        len            <= '0;
        digest_q       <= '0;
        digest_ready_q <= 1'b0;
      end
      if (do_msg) begin
        b   <= msg_byte;
        rnd <= '0;
      end
      if (do_tail) begin
        lb  <= '0;
        rnd <= '0;
        // with no trailer the current state is already the digest
        if (LEN_BYTES == 0) begin
          digest_q       <= h;
          digest_ready_q <= 1'b1;
        end
      end
      if (do_round) begin
        h   <= h_round;
        rnd <= last_rnd ? 8'd0 : rnd + 8'd1;
        if (state == ABSORB && last_rnd) len <= len + LEN_W'(1);
        if (state == FINAL && last_rnd) begin
          lb <= lb + 2'd1;
          if (last_lb) begin
            digest_q       <= h_round;
            digest_ready_q <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_light_hash_param.sv
// Self-checking bench for light_hash_param: default instance plus a one-byte
// instance, both checked against a byte-stream reference hash.
module tb_light_hash_param;

  typedef logic [7:0] byte_q_t[$];

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  cmd = 2'b00;
  logic [7:0]  msg_byte = 8'h00;
  logic        v0 = 1'b0, v1 = 1'b0;
  logic        rdy0, rdy1, dr0, dr1, bz0, bz1;
  logic [63:0] dg0;
  logic [7:0]  dg1;

  int checks = 0;
  int errors = 0;
  logic [7:0] sbox_tab[256];

  localparam logic [63:0] IV0 = 64'h0123456789abcdef;

  always #5 clk = ~clk;

  light_hash_param dut0 (
    .clk(clk), .rst_n(rst_n), .cmd(cmd), .msg_byte(msg_byte), .msg_valid(v0),
    .msg_ready(rdy0), .digest(dg0), .digest_ready(dr0), .busy(bz0)
  );

  light_hash_param #(.DIGEST_W(8), .ROUNDS(1), .LEN_BYTES(1), .IV(8'h00)) dut1 (
    .clk(clk), .rst_n(rst_n), .cmd(cmd), .msg_byte(msg_byte), .msg_valid(v1),
    .msg_ready(rdy1), .digest(dg1), .digest_ready(dr1), .busy(bz1)
  );

  function automatic logic [7:0] rot(input logic [7:0] x, input int r);
    logic [7:0] y;
    if (r == 0) y = x;
    else y = (x << r) | (x >> (8 - r));
    return y;
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic hi;
    for (int k = 0; k < 8; k++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a = a << 1;
      if (hi) a = a ^ 8'h1b;
      b = b >> 1;
    end
    return p;
  endfunction

  // S-box from first principles: GF(2^8) inverse followed by the affine map
  task automatic build_sbox();
    logic [7:0] inv;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int c = 1; c < 256; c++)
        if (gf_mul(8'(a), 8'(c)) == 8'h01) inv = 8'(c);
      sbox_tab[a] = inv ^ rot(inv, 1) ^ rot(inv, 2) ^ rot(inv, 3) ^ rot(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [255:0] ref_hash(input int n, input int rounds, input int lenb,
                                            input logic [255:0] iv, input byte_q_t msg);
    logic [7:0] h[32];
    logic [7:0] t[32];
    byte_q_t stream;
    logic [255:0] r = '0;
    int unsigned sz;
    for (int i = 0; i < n; i++) h[i] = iv[8*i +: 8];
    stream = msg;
    sz = msg.size();
    for (int k = 0; k < lenb; k++) stream.push_back(8'((sz >> (8*k)) & 255));
    foreach (stream[j])
      for (int rr = 0; rr < rounds; rr++) begin
        for (int i = 0; i < n; i++)
          t[i] = sbox_tab[h[(i+1) % n] ^ stream[j]] ^ rot(h[i], i % 8);
        for (int i = 0; i < n; i++) h[i] = t[i];
      end
    for (int i = 0; i < n; i++) r[8*i +: 8] = h[i];
    return r;
  endfunction

  task automatic send(input int which, input logic [1:0] c, input logic [7:0] d);
    int g = 0;
    @(negedge clk);
    while (!(which == 1 ? rdy1 : rdy0) && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (g >= 200) begin
      checks++; errors++;
      $display("FAIL send_timeout dut%0d msg_ready never rose, need 1", which);
    end
    cmd = c; msg_byte = d;
    if (which == 1) v1 = 1'b1; else v0 = 1'b1;
    @(posedge clk); #1;
    v0 = 1'b0; v1 = 1'b0;
  endtask

  task automatic hash_run(input int which, input byte_q_t msg, input bit rsvd,
                          output logic [255:0] dg, output int lat);
    send(which, 2'b00, 8'h00);
    foreach (msg[i]) begin
      if (rsvd && $urandom_range(0, 2) == 0) send(which, 2'b11, 8'($urandom));
      send(which, 2'b10, msg[i]);
    end
    send(which, 2'b01, 8'h00);
    lat = 0;
    while (!(which == 1 ? dr1 : dr0) && lat < 2000) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!(which == 1 ? dr1 : dr0)) begin
      checks++; errors++;
      $display("FAIL digest_timeout dut%0d digest_ready=0 after %0d cycles, need 1", which, lat);
    end
    dg = (which == 1) ? 256'(dg1) : 256'(dg0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (dg0 !== 64'h0) begin errors++; $display("FAIL rst_digest got %h need 0", dg0); end
    checks++; if (dr0 !== 1'b0) begin errors++; $display("FAIL rst_digest_ready got %b need 0", dr0); end
    checks++; if (rdy0 !== 1'b1) begin errors++; $display("FAIL rst_msg_ready got %b need 1", rdy0); end
    checks++; if (bz0 !== 1'b0) begin errors++; $display("FAIL rst_busy got %b need 0", bz0); end
    checks++; if ({dg1, dr1, rdy1, bz1} !== 11'b00000000_0_1_0) begin
      errors++; $display("FAIL rst_dut1 got %h/%b/%b/%b need 00/0/1/0", dg1, dr1, rdy1, bz1);
    end
    rst_n = 1'b1;
    send(0, 2'b00, 8'h00);
    checks++; if (dr0 !== 1'b0) begin errors++; $display("FAIL head_digest_ready got %b need 0", dr0); end
  endtask

  task automatic test_small();
    logic [255:0] dg, exp_dg;
    int lat;
    byte_q_t m;
    send(1, 2'b00, 8'h00);
    send(1, 2'b01, 8'h00);
    checks++; if (dr1 !== 1'b0) begin errors++; $display("FAIL small_early_ready got %b need 0", dr1); end
    @(posedge clk); #1;
    checks++; if (dr1 !== 1'b1) begin errors++; $display("FAIL small_empty_ready got %b need 1", dr1); end
    checks++; if (dg1 !== 8'h63) begin errors++; $display("FAIL small_empty_digest got %h need 63", dg1); end
    m = '{8'h00};
    hash_run(1, m, 1'b0, dg, lat);
    checks++; if (dg[7:0] !== 8'hc9) begin errors++; $display("FAIL small_msg00_digest got %h need c9", dg[7:0]); end
    checks++; if (lat !== 1) begin errors++; $display("FAIL small_latency got %0d need 1", lat); end
    for (int k = 0; k < 5; k++) begin
      m = {};
      for (int j = 0; j < int'($urandom_range(0, 6)); j++) m.push_back(8'($urandom));
      hash_run(1, m, 1'b1, dg, lat);
      exp_dg = ref_hash(1, 1, 1, 256'h0, m);
      checks++; if (dg[7:0] !== exp_dg[7:0]) begin
        errors++; $display("FAIL small_rand%0d len=%0d got %h need %h", k, m.size(), dg[7:0], exp_dg[7:0]);
      end
    end
  endtask

  task automatic test_handshake();
    int low = 0, bsy = 0, lat = 0;
    logic [7:0] x, y;
    logic [255:0] exp_dg;
    byte_q_t m;
    x = 8'($urandom); y = ~x;
    send(0, 2'b00, 8'h00);
    @(negedge clk);
    cmd = 2'b10; msg_byte = x; v0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    msg_byte = y;
    while (!rdy0 && low < 100) begin
      low++;
      if (bz0) bsy++;
      @(negedge clk);
    end
    v0 = 1'b0;
    checks++; if (low !== 32) begin errors++; $display("FAIL hs_ready_low got %0d cycles need 32", low); end
    checks++; if (bsy !== 32) begin errors++; $display("FAIL hs_busy_high got %0d cycles need 32", bsy); end
    send(0, 2'b01, 8'h00);
    while (!dr0 && lat < 2000) begin @(posedge clk); #1; lat++; end
    m = '{x};
    exp_dg = ref_hash(8, 32, 1, 256'(IV0), m);
    checks++; if (dg0 !== exp_dg[63:0]) begin
      errors++; $display("FAIL hs_held_not_consumed got %h need %h", dg0, exp_dg[63:0]);
    end
  endtask

  task automatic test_random();
    logic [255:0] dg, exp_dg;
    int lat;
    byte_q_t m;
    for (int k = 0; k < 6; k++) begin
      m = {};
      for (int j = 0; j < int'($urandom_range(0, 5)); j++) m.push_back(8'($urandom));
      hash_run(0, m, 1'b1, dg, lat);
      exp_dg = ref_hash(8, 32, 1, 256'(IV0), m);
      checks++; if (dg[63:0] !== exp_dg[63:0]) begin
        errors++; $display("FAIL rand%0d len=%0d got %h need %h", k, m.size(), dg[63:0], exp_dg[63:0]);
      end
      checks++; if (lat !== 32) begin errors++; $display("FAIL rand%0d_latency got %0d need 32", k, lat); end
    end
    // 257 bytes: the one-byte length trailer wraps to 1
    m = {};
    for (int j = 0; j < 257; j++) m.push_back(8'($urandom));
    hash_run(0, m, 1'b0, dg, lat);
    exp_dg = ref_hash(8, 32, 1, 256'(IV0), m);
    checks++; if (dg[63:0] !== exp_dg[63:0]) begin
      errors++; $display("FAIL len_wrap got %h need %h", dg[63:0], exp_dg[63:0]);
    end
  endtask

  task automatic test_done_drop();
    logic [255:0] dg, dg2, exp_dg;
    int lat;
    byte_q_t m;
    m = '{8'h68, 8'h61, 8'h73, 8'h68};
    hash_run(0, m, 1'b0, dg, lat);
    exp_dg = ref_hash(8, 32, 1, 256'(IV0), m);
    checks++; if (dg[63:0] !== exp_dg[63:0]) begin
      errors++; $display("FAIL done_first got %h need %h", dg[63:0], exp_dg[63:0]);
    end
    send(0, 2'b10, 8'h5a);
    send(0, 2'b01, 8'h00);
    send(0, 2'b11, 8'hff);
    repeat (3) @(negedge clk);
    checks++; if (dg0 !== exp_dg[63:0] || dr0 !== 1'b1 || bz0 !== 1'b0) begin
      errors++; $display("FAIL done_hold got %h/%b/%b need %h/1/0", dg0, dr0, bz0, exp_dg[63:0]);
    end
    send(0, 2'b00, 8'h00);
    checks++; if (dr0 !== 1'b0 || dg0 !== 64'h0) begin
      errors++; $display("FAIL done_head got %h/%b need 0/0", dg0, dr0);
    end
    hash_run(0, m, 1'b0, dg2, lat);
    checks++; if (dg2[63:0] !== exp_dg[63:0]) begin
      errors++; $display("FAIL rehash got %h need %h", dg2[63:0], exp_dg[63:0]);
    end
  endtask

  task automatic test_reset_mid();
    logic [255:0] dg, exp_dg;
    int lat;
    byte_q_t m;
    send(0, 2'b00, 8'h00);
    send(0, 2'b10, 8'h61);
    repeat (9) @(posedge clk);
    #2;
    checks++; if (bz0 !== 1'b1) begin errors++; $display("FAIL mid_busy_before got %b need 1", bz0); end
    rst_n = 1'b0;
    #1;
    checks++; if ({dg0, dr0, rdy0, bz0} !== {64'h0, 3'b010}) begin
      errors++; $display("FAIL mid_reset got %h/%b/%b/%b need 0/0/1/0", dg0, dr0, rdy0, bz0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    m = '{8'h61, 8'h62};
    hash_run(0, m, 1'b0, dg, lat);
    exp_dg = ref_hash(8, 32, 1, 256'(IV0), m);
    checks++; if (dg[63:0] !== exp_dg[63:0]) begin
      errors++; $display("FAIL mid_rehash_ab got %h need %h", dg[63:0], exp_dg[63:0]);
    end
  endtask

  initial begin
    build_sbox();
    test_reset();
    test_small();
    test_handshake();
    test_random();
    test_done_drop();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
